// File: rtl/onchip_mem_fill_engine.sv
// Fills a word range of the on-chip RAM with seed / seed+index, optionally
// verifying it (ONCHIP_MEM_FILL_VERIFY_EN). Ports: clk, reset_n, start/abort,
// base/length/mode/seed request, busy/done/range_err/mismatch/err_count/
// first_err_addr status, Avalon-MM RAM master (mem_*).
module onchip_mem_fill_engine #(
  parameter int DEPTH = 24500,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   length,
  input  logic          mode,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic          mismatch,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

  state_t        state;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt;
  logic          mode_q;
  logic [31:0]   seed_q;
  logic [AW+1:0] req_end;

  assign req_end   = {2'b00, base} + {1'b0, length};
  assign mem_clken = 1'b1;

  function automatic logic [31:0] pat(
    input logic        m,
    input logic [31:0] s,
    input logic [AW:0] i
  );
    return m ? s + 32'(i) : s;
  endfunction

`ifdef ONCHIP_MEM_FILL_VERIFY_EN
  logic          pipe_v;
  logic [AW:0]   pipe_idx;
  logic [AW-1:0] pipe_addr;
`else
  logic unused_rd;
  assign unused_rd      = ^mem_readdata;
  assign mismatch       = 1'b0;
  assign err_count      = 16'h0;
  assign first_err_addr = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      cnt            <= '0;
      mode_q         <= 1'b0;
      seed_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      range_err      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= 4'h0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
`ifdef ONCHIP_MEM_FILL_VERIFY_EN
      pipe_v         <= 1'b0;
      pipe_idx       <= '0;
      pipe_addr      <= '0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base;
            len_q     <= length;
            mode_q    <= mode;
            seed_q    <= seed;
            busy      <= 1'b1;
            range_err <= 1'b0;
`ifdef ONCHIP_MEM_FILL_VERIFY_EN
            mismatch       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
`endif
            if (req_end > DEPTH_L) begin
              range_err <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else if (length == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // pat(0) is the seed in both modes
              state          <= S_FILL;
              cnt            <= 1;
              mem_address    <= base;
              mem_writedata  <= seed;
              mem_byteenable <= 4'hF;
              mem_chipselect <= 1'b1;
              mem_write      <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (abort || cnt == len_q) begin
            mem_write     <= 1'b0;
            mem_writedata <= '0;
`ifdef ONCHIP_MEM_FILL_VERIFY_EN
            if (!abort) begin
              state       <= S_VERIFY;
              cnt         <= 1;
              mem_address <= base_q;
            end else begin
              mem_chipselect <= 1'b0;
              mem_byteenable <= 4'h0;
              mem_address    <= '0;
              done           <= 1'b1;
              state          <= S_DONE;
            end
`else
            mem_chipselect <= 1'b0;
            mem_byteenable <= 4'h0;
            mem_address    <= '0;
            done           <= 1'b1;
            state          <= S_DONE;
`endif
          end else begin
            mem_address   <= base_q + cnt[AW-1:0];
            mem_writedata <= pat(mode_q, seed_q, cnt);
            cnt           <= cnt + 1'b1;
          end
        end
        S_VERIFY: begin
          if (abort || cnt == len_q) begin
            mem_chipselect <= 1'b0;
            mem_byteenable <= 4'h0;
            mem_address    <= '0;
            if (abort) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            mem_address <= base_q + cnt[AW-1:0];
            cnt         <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef ONCHIP_MEM_FILL_VERIFY_EN
      // the read completing on an abort edge is dropped
      pipe_v    <= mem_chipselect && !mem_write &&
                   !(abort && state == S_VERIFY);
      pipe_idx  <= cnt - 1'b1;
      pipe_addr <= mem_address;
      if (pipe_v && mem_readdata != pat(mode_q, seed_q, pipe_idx)) begin
        mismatch <= 1'b1;
        if (err_count != 16'hFFFF)
          err_count <= err_count + 1'b1;
        if (err_count == '0)
          first_err_addr <= pipe_addr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_onchip_mem_fill_engine.sv
// Scoreboard bench for onchip_mem_fill_engine: expected RAM accesses and
// done records are queued by the stimulus and popped by a negedge monitor.
module tb_onchip_mem_fill_engine;

  localparam int DEPTH = 24500;
  localparam int AW    = 15;

`ifdef ONCHIP_MEM_FILL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base;
  logic [AW:0]   length;
  logic          mode;
  logic [31:0]   seed;
  logic          busy;
  logic          done;
  logic          range_err;
  logic          mismatch;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [31:0]   mem_writedata;
  logic          mem_clken;
  logic [31:0]   mem_readdata;

  onchip_mem_fill_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .base(base),
    .length(length),
    .mode(mode),
    .seed(seed),
    .busy(busy),
    .done(done),
    .range_err(range_err),
    .mismatch(mismatch),
    .err_count(err_count),
    .first_err_addr(first_err_addr),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    bit          rerr;
    bit          mm;
    int          cnt;
    int          fa;
  } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;
  int    start_edge = 0;
  int    done_seen = 0;
  int    corrupt_addr = -1;

  logic [31:0] ram [DEPTH];

  // RAM model; corrupt_addr has bit 3 flipped on read
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (mem_chipselect) begin
      if (mem_write)
        ram[mem_address] <= mem_writedata;
      else if (int'(mem_address) == corrupt_addr)
        mem_readdata <= ram[mem_address] ^ 32'h8;
      else
        mem_readdata <= ram[mem_address];
    end
  end

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_chipselect) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", 1, 0);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("acc_write", mem_write, a.wr);
          chk("acc_addr", mem_address, a.addr);
          chk("acc_be", mem_byteenable, 4'hF);
          if (a.wr)
            chk("acc_data", mem_writedata, a.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_cycle", edge_cnt - start_edge, d.cyc);
          chk("done_busy", busy, 1);
          chk("done_range_err", range_err, d.rerr);
          chk("done_mismatch", mismatch, d.mm);
          chk("done_err_count", err_count, d.cnt);
          chk("done_first_err", first_err_addr, d.fa);
          chk("done_acc_left", acc_q.size(), 0);
        end
        done_seen++;
      end
    end
  end

  task automatic push_expect(input int b, input int n, input bit m,
                             input logic [31:0] s, input int corrupt,
                             input int abort_at);
    bit    rerr;
    bit    ab;
    int    nw;
    int    errs;
    done_t d;
    rerr = (b + n) > DEPTH;
    ab   = !rerr && n > 0 && abort_at > 0 && abort_at < n;
    nw   = (rerr || n == 0) ? 0 : (ab ? abort_at : n);
    for (int i = 0; i < nw; i++)
      acc_q.push_back('{1'b1, b + i, m ? s + 32'(i) : s});
    errs = 0;
    if (VER && !ab && !rerr) begin
      for (int i = 0; i < n; i++)
        acc_q.push_back('{1'b0, b + i, 32'h0});
      if (corrupt >= b && corrupt < b + n)
        errs = 1;
    end
    if (rerr || n == 0)
      d.cyc = 1;
    else if (ab)
      d.cyc = abort_at + 1;
    else
      d.cyc = VER ? 2 * n + 2 : n + 1;
    d.rerr = rerr;
    d.mm   = errs > 0;
    d.cnt  = errs;
    d.fa   = errs > 0 ? corrupt : 0;
    done_q.push_back(d);
  endtask

  task automatic run_op(input int b, input int n, input bit m,
                        input logic [31:0] s, input int corrupt,
                        input int abort_at, input bit busy_start);
    int seen0;
    int cyc;
    int lim;
    push_expect(b, n, m, s, corrupt, abort_at);
    corrupt_addr = corrupt;
    @(negedge clk);
    #1;
    start      = 1'b1;
    base       = AW'(b);
    length     = (AW+1)'(n);
    mode       = m;
    seed       = s;
    start_edge = edge_cnt;
    seen0      = done_seen;
    lim        = 2 * n + 20;
    for (int k = 0; k <= lim; k++) begin
      @(negedge clk);
      #1;
      cyc = edge_cnt - start_edge;
      if (done_seen != seen0)
        break;
      if (k == lim) begin
        chk("done_timeout", cyc, -1);
        break;
      end
      abort  = abort_at > 0 && cyc == abort_at;
      start  = busy_start && cyc == 2;
      base   = AW'($urandom_range(0, 99));
      length = (AW+1)'($urandom_range(1, 5));
      seed   = $urandom;
      mode   = 1'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_after_done", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_range_err"}, range_err, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_err"}, first_err_addr, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_be"}, mem_byteenable, 0);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_we"}, mem_write, 0);
    chk({tag, "_wdata"}, mem_writedata, 0);
    chk({tag, "_clken"}, mem_clken, 1);
  endtask

  initial begin
    int b;
    int n;
    int c;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    base    = '0;
    length  = '0;
    mode    = 1'b0;
    seed    = '0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset in the middle of a fill: 50 writes reach the RAM first
    for (int i = 0; i < 50; i++)
      acc_q.push_back('{1'b1, i, 32'h1234_0000 + 32'(i)});
    @(negedge clk);
    #1;
    start      = 1'b1;
    base       = '0;
    length     = 100;
    mode       = 1'b1;
    seed       = 32'h1234_0000;
    start_edge = edge_cnt;
    @(negedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (edge_cnt - start_edge >= 50)
        break;
      @(negedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_acc_left", acc_q.size(), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(100, 8, 1'b1, 32'hFFFF_FFFE, 105, 0, 1'b0);
    run_op(24499, 2, 1'b0, 32'hDEAD_BEEF, -1, 0, 1'b0);
    run_op(300, 0, 1'b1, 32'h5, -1, 0, 1'b0);
    run_op(DEPTH - 4, 4, 1'b1, 32'h7FFF_FFFF, DEPTH - 1, 0, 1'b0);
    run_op(10, 50, 1'b1, 32'hA5A5_0000, -1, 5, 1'b1);
    run_op(2000, 20, 1'b0, 32'hCAFE_F00D, -1, 0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0)
        b = DEPTH - $urandom_range(0, 30);
      else
        b = $urandom_range(0, DEPTH - 64);
      n = $urandom_range(0, 40);
      c = $urandom_range(0, 1) != 0 ? b + $urandom_range(0, n) : -1;
      run_op(b, n, 1'($urandom), $urandom, c, 0, 1'b0);
    end

    run_op(0, DEPTH, 1'b0, 32'h0, -1, 0, 1'b0);

    chk("final_acc_q", acc_q.size(), 0);
    chk("final_done_q", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
